d_cache_2way: RTL
=================

# d_cache_2way

Two-way set-associative, write-back, write-allocate data cache with parametrised line length and burst refill/write-back. It sits between the CPU memory stage and the data memory bus, with the same `p_*` (CPU side) and `m_*` (memory side) handshake as the existing direct-mapped data cache. It adds multi-word lines, per-set LRU replacement and sequential line transfers. Uncached address windows bypass the arrays entirely.

## Interface
- A_WIDTH, 32, address width
- C_INDEX, 7, log2(number of sets)
- L_OFF, 2, log2(words per line); LW = 1<<L_OFF
- Derived: T_WIDTH = A_WIDTH-C_INDEX-L_OFF-2

Ports (name, direction, width, meaning):
- clk  in  1  clock, all state on rising edge
- rst  in  1  one clock; reset is synchronous and active-high
- p_a  in  A_WIDTH  CPU byte address
- p_dout  in  32  CPU store data
- p_din  out  32  load data to CPU
- p_strobe  in  1  CPU request valid
- p_wen  in  4  byte enables, bit3 = [31:24]
- p_size  in  2  access size (passed through only when uncached)
- p_rw  in  1  0 read, 1 write
- p_ready  out  1  request complete this cycle
- m_a  out  A_WIDTH  memory address
- m_dout  in  32  memory read data
- m_din  out  32  memory write data
- m_strobe  out  1  memory request valid
- m_wen  out  4  memory byte enables
- m_size  out  2  memory access size
- m_rw  out  1  0 read, 1 write
- m_ready  in  1  memory word transfer complete

## Operation
- Address split: tag = p_a[A_WIDTH-1:C_INDEX+L_OFF+2], index = p_a[C_INDEX+L_OFF+1:L_OFF+2], word = p_a[L_OFF+1:2].
- Per set, per way: valid, dirty, tag, LW×4 byte lanes. Per set: one LRU bit naming the way to replace next.
- Uncached: p_a[31:29]==3'b101 or p_a[31:28]==4'b1000.
  - m_a = {3'b000,p_a[28:0]}; m_din/m_strobe/m_wen/m_size/m_rw mirror p_*.
  - p_din = m_dout; p_ready = p_strobe & m_ready.
  - No array, LRU or FSM change.
- Hit means p_strobe & cached & valid[w] & tag match in way w. At most one way may match.
  - Read: p_din = addressed word of way w.
  - Write: update the bytes selected by p_wen (any pattern, including 0000) and set dirty[w].
  - Both: set LRU to the other way (~w).
- Victim selection on miss: invalid way0, else invalid way1, else way LRU.
- FSM states: IDLE, WB, RF.
  - IDLE→WB: cached miss with a valid and dirty victim.
  - IDLE→RF: cached miss with a clean or invalid victim.
  - WB: m_rw=1, m_wen=1111, m_size=10, m_a={victim tag,index,cnt,2'b00}, m_din=victim word cnt. cnt advances on m_ready; after word LW-1 go to RF with cnt=0.
  - RF: m_rw=0, m_wen=1111, m_size=10, m_a={tag,index,cnt,2'b00}. Each m_ready writes m_dout into victim word cnt. On the last word also write valid=1, dirty=0, tag, and LRU=~victim, then go to IDLE.
  - The original request is then served as a hit in IDLE; a write merges at that point.
- The victim way is latched on entry to WB/RF. cnt is L_OFF bits and wraps to 0 at the end of each phase.
- While the FSM is not in IDLE, p_a, p_rw, p_wen and p_dout must be held stable by the CPU. If p_strobe drops mid-line, the transfer still completes; nothing is served afterwards.

## Timing
- Reset state: state=IDLE, cnt=0, all valid/dirty/LRU = 0.
- While rst is high: p_ready=0, m_strobe=0, p_din=0. Data/tag arrays are not cleared.
- Reset mid-WB/RF abandons the line. m_strobe is low in the cycle rst is sampled. The partially filled way stays invalid.
- p_din = 0 whenever there is neither a hit nor an uncached access.
- Hit: p_ready combinational in the same cycle (0 wait states).
- Cached miss, memory ready every cycle (request cycle = 0):
  - Clean miss: RF occupies cycles 1..LW; p_ready at cycle LW+1.
  - Dirty miss: WB occupies cycles 1..LW, RF occupies LW+1..2LW; p_ready at cycle 2LW+1.
- Memory stall (m_ready=0): m_a, m_din and cnt hold; m_strobe stays high.
- m_strobe is combinational: high in WB/RF, or for an uncached p_strobe.

## Test plan
- Clean read miss at 0x0000_1000, memory returns 0x11111111/0x22222222/0x33333333/0x44444444 with m_ready each cycle -> m_a = 0x1000,0x1004,0x1008,0x100C on cycles 1-4; p_ready=1, p_din=0x11111111 at cycle 5.
- Write 0x0000_1004 with p_wen=0001, p_dout=0x000000AB after that fill -> same-cycle p_ready, no m_strobe. A following read of 0x1004 returns 0x222222AB.
- Read 0x1000 (fills way0), read 0x2000 (fills way1), write 0x2000, read 0x1000 (hit), read 0x3000 -> write-back of 4 words starting 0x2000 with the modified word, then refill from 0x3000. A read of 0x1000 still hits.
- Uncached read 0xBFC0_0004 with m_ready after 3 cycles -> m_a=0x1FC0_0004, p_ready only in the m_ready cycle, p_din=m_dout. A later cached access shows no array or LRU change.
- Stall m_ready low 3 cycles on RF word 1 -> m_a holds 0x1004, cnt holds, p_ready delayed by exactly 3 cycles.
- Assert rst during RF word 2 -> m_strobe=0 the same cycle. After release, reading 0x1000 misses and refetches all 4 words.

Source files
------------

// File: rtl/d_cache_2way.sv
// Two-way set-associative write-back/write-allocate data cache with per-set LRU,
// sequential line refill/write-back bursts and uncached bypass windows.
module d_cache_2way #(
   parameter int A_WIDTH = 32,
   parameter int C_INDEX = 7,
   parameter int L_OFF   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [A_WIDTH-1:0] p_a,
   input  logic [31:0]        p_dout,
   output logic [31:0]        p_din,
   input  logic               p_strobe,
   input  logic [3:0]         p_wen,
   input  logic [1:0]         p_size,
   input  logic               p_rw,
   output logic               p_ready,
   output logic [A_WIDTH-1:0] m_a,
   input  logic [31:0]        m_dout,
   output logic [31:0]        m_din,
   output logic               m_strobe,
   output logic [3:0]         m_wen,
   output logic [1:0]         m_size,
   output logic               m_rw,
   input  logic               m_ready
);
   localparam int LW      = 1 << L_OFF;
   localparam int SETS    = 1 << C_INDEX;
   localparam int T_WIDTH = A_WIDTH - C_INDEX - L_OFF - 2;

   typedef enum logic [1:0] {IDLE = 2'd0, WB = 2'd1, RF = 2'd2} state_t;

   state_t             state_r, state_nx_s;
   logic [L_OFF-1:0]   cnt_r, cnt_nx_s;
   logic               victim_r, victim_nx_s;
   logic [SETS-1:0]    valid_r [2];
   logic [SETS-1:0]    dirty_r [2];
   logic [SETS-1:0]    lru_r;
   logic [T_WIDTH-1:0] tag_r [2][SETS];
   logic [31:0]        data_r [2][SETS*LW];

   logic [T_WIDTH-1:0] tag_s;
   logic [C_INDEX-1:0] idx_s;
   logic [L_OFF-1:0]   word_s;
   logic [1:0]         match_s;
   logic               uncached_s, cached_req_s, hit_s, miss_s, hit_way_s;
   logic               pick_s, last_s, fill_s, unused_s;

   assign tag_s        = p_a[A_WIDTH-1 -: T_WIDTH];
   assign idx_s        = p_a[C_INDEX+L_OFF+1 : L_OFF+2];
   assign word_s       = p_a[L_OFF+1:2];
   assign unused_s     = ^p_a[1:0];
   assign uncached_s   = (p_a[31:29] == 3'b101) | (p_a[31:28] == 4'b1000);
   assign cached_req_s = p_strobe & ~uncached_s & ~rst & (state_r == IDLE);
   assign match_s[0]   = valid_r[0][idx_s] & (tag_r[0][idx_s] == tag_s);
   assign match_s[1]   = valid_r[1][idx_s] & (tag_r[1][idx_s] == tag_s);
   assign hit_s        = cached_req_s & (|match_s);
   assign miss_s       = cached_req_s & ~(|match_s);
   assign hit_way_s    = match_s[1];
   // Victim: invalid way0 first, then invalid way1, otherwise the LRU way
   assign pick_s       = ~valid_r[0][idx_s] ? 1'b0 : (~valid_r[1][idx_s] ? 1'b1 : lru_r[idx_s]);
   assign last_s       = &cnt_r;
   assign fill_s       = (state_r == RF) & m_ready & ~rst;

   // Next-state logic for the line-transfer sequencer
   always_comb begin
      state_nx_s  = state_r;
      cnt_nx_s    = cnt_r;
      victim_nx_s = victim_r;
      case (state_r)
         IDLE: begin
            if (miss_s) begin
               victim_nx_s = pick_s;
               if (valid_r[pick_s][idx_s] & dirty_r[pick_s][idx_s]) begin
                  state_nx_s = WB;
               end else begin
                  state_nx_s = RF;
               end
            end else begin
               state_nx_s = IDLE;
            end
         end
         WB: begin
            if (m_ready) begin
               cnt_nx_s   = cnt_r + L_OFF'(1);
               state_nx_s = last_s ? RF : WB;
            end else begin
               state_nx_s = WB;
            end
         end
         RF: begin
            if (m_ready) begin
               cnt_nx_s   = cnt_r + L_OFF'(1);
               state_nx_s = last_s ? IDLE : RF;
            end else begin
               state_nx_s = RF;
            end
         end
         default: begin
            state_nx_s = IDLE;
            cnt_nx_s   = {L_OFF{1'b0}};
         end
      endcase
   end

   // CPU and memory bus outputs; uncached requests pass straight through
   always_comb begin
      p_din    = 32'd0;
      p_ready  = 1'b0;
      m_a      = {{(A_WIDTH-29){1'b0}}, p_a[28:0]};
      m_din    = p_dout;
      m_strobe = 1'b0;
      m_wen    = p_wen;
      m_size   = p_size;
      m_rw     = p_rw;
      if (rst) begin
         m_strobe = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (p_strobe & uncached_s) begin
                  m_strobe = 1'b1;
                  p_din    = m_dout;
                  p_ready  = m_ready;
               end else if (hit_s) begin
                  p_din    = data_r[hit_way_s][{idx_s, word_s}];
                  p_ready  = 1'b1;
               end else begin
                  m_strobe = 1'b0;
               end
            end
            WB: begin
               m_strobe = 1'b1;
               m_rw     = 1'b1;
               m_wen    = 4'b1111;
               m_size   = 2'b10;
               m_a      = {tag_r[victim_r][idx_s], idx_s, cnt_r, 2'b00};
               m_din    = data_r[victim_r][{idx_s, cnt_r}];
            end
            RF: begin
               m_strobe = 1'b1;
               m_rw     = 1'b0;
               m_wen    = 4'b1111;
               m_size   = 2'b10;
               m_a      = {tag_s, idx_s, cnt_r, 2'b00};
            end
            default: begin
               m_strobe = 1'b0;
            end
         endcase
      end
   end

   // Sequencer state and per-set valid/dirty/LRU bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         cnt_r      <= {L_OFF{1'b0}};
         victim_r   <= 1'b0;
         valid_r[0] <= {SETS{1'b0}};
         valid_r[1] <= {SETS{1'b0}};
         dirty_r[0] <= {SETS{1'b0}};
         dirty_r[1] <= {SETS{1'b0}};
         lru_r      <= {SETS{1'b0}};
      end else begin
         state_r  <= state_nx_s;
         cnt_r    <= cnt_nx_s;
         victim_r <= victim_nx_s;
         if (hit_s) begin
            lru_r[idx_s] <= ~hit_way_s;
            if (p_rw) begin
               dirty_r[hit_way_s][idx_s] <= 1'b1;
            end
         end else if (fill_s & last_s) begin
            valid_r[victim_r][idx_s] <= 1'b1;
            dirty_r[victim_r][idx_s] <= 1'b0;
            lru_r[idx_s]             <= ~victim_r;
         end
      end
   end

   // Line storage; contents survive reset and are qualified by the valid bits
   always_ff @(posedge clk) begin
      if (hit_s & p_rw) begin
         for (int b = 0; b < 4; b++) begin
            if (p_wen[b]) begin
               data_r[hit_way_s][{idx_s, word_s}][8*b +: 8] <= p_dout[8*b +: 8];
            end
         end
      end else if (fill_s) begin
         data_r[victim_r][{idx_s, cnt_r}] <= m_dout;
         if (last_s) begin
            tag_r[victim_r][idx_s] <= tag_s;
         end
      end
   end
endmodule
